// File: rtl/id_ex_skid_register.sv
// ID/EX pipeline register with a one-entry skid buffer.
// Handshake outputs are decoded from registered state only, and a saturating counter tracks back-pressure cycles.
module id_ex_skid_register #(
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_ra,
    input  logic [31:0]            in_rb,
    input  logic [20:0]            in_imm,
    input  logic [2:0]             in_oh_sel,
    input  logic [3:0]             in_alu_op,
    input  logic [4:0]             in_rd,
    input  logic                   in_rf_we,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_ra,
    output logic [31:0]            out_rb,
    output logic [20:0]            out_imm,
    output logic [2:0]             out_oh_sel,
    output logic [3:0]             out_alu_op,
    output logic [4:0]             out_rd,
    output logic                   out_rf_we,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [31:0] ra;
        logic [31:0] rb;
        logic [20:0] imm;
        logic [2:0]  oh_sel;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        logic        rf_we;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    bundle_t                main_q, main_d;
    bundle_t                skid_q, skid_d;
    bundle_t                in_b;
    logic                   out_valid_q;
    logic                   in_ready_q;
    logic [1:0]             occ_q;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   accept;
    logic                   fire;

    assign in_b = '{ra: in_ra, rb: in_rb, imm: in_imm, oh_sel: in_oh_sel,
                    alu_op: in_alu_op, rd: in_rd, rf_we: in_rf_we};

    assign accept = in_valid & in_ready_q;
    assign fire   = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = in_b;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && fire) begin
                    main_d = in_b;
                end else if (accept) begin
                    skid_d  = in_b;
                    state_d = FULL;
                end else if (fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush drops only the valid state; payload registers keep their contents.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end

        if (out_valid_q && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occ_q       <= 2'd0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != EMPTY);
            in_ready_q  <= (state_d != FULL);
            occ_q       <= (state_d == FULL) ? 2'd2 : ((state_d == ONE) ? 2'd1 : 2'd0);
            stall_q     <= stall_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign in_ready   = in_ready_q;
    assign occupancy  = occ_q;
    assign stall_cnt  = stall_q;
    assign out_ra     = main_q.ra;
    assign out_rb     = main_q.rb;
    assign out_imm    = main_q.imm;
    assign out_oh_sel = main_q.oh_sel;
    assign out_alu_op = main_q.alu_op;
    assign out_rd     = main_q.rd;
    assign out_rf_we  = main_q.rf_we;

endmodule
